key_press_classifier: RTL and testbench
=======================================

Name: key_press_classifier

Overview:
- Front end for the button that drives the clock state machine.
- Synchronises the raw push-button input and debounces both edges.
- Classifies each press, then emits a one-cycle key_short pulse (released before the long threshold) or a one-cycle key_long pulse (held to the threshold).
- Its outputs connect directly to the key_short/key_long inputs of the clock state machine.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable samples needed to accept a press or a release (10 ms at 50 MHz); legal range >= 2.
- LONG_CYCLES, 50000000: debounced hold time in cycles that makes a press long (1 s at 50 MHz); legal range >= 2.
- KEY_ACTIVE_LOW, 1: 1 means key_raw = 0 when pressed; 0 means key_raw = 1 when pressed.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- key_raw  input  1  asynchronous, bouncing button level.
- key_short  output  1  one-cycle pulse: short press completed.
- key_long  output  1  one-cycle pulse: long threshold reached.
- key_pressed  output  1  debounced press level (debug/LED).
- state  output  3  current FSM state (debug).

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All outputs are registered.
- Reset:
  - 2-FF synchroniser loads the released level.
  - state = IDLE (0); all counters = 0; short_pending = 0.
  - key_short = key_long = key_pressed = 0.
- Input path:
  - key_raw passes through a 2-FF synchroniser, then is polarity-corrected to key_s (1 = pressed).
  - If key_raw first presents a new level at edge E0, the FSM first samples it at E2.
- State encoding: IDLE=0, DB_PRESS=1, PRESSED=2, LONG_HELD=3, DB_RELEASE=4. Codes 5-7 go to IDLE on the next edge with outputs 0.
- IDLE: key_s=1 -> DB_PRESS, cnt<=1.
- DB_PRESS:
  - key_s=0 -> IDLE (bounce rejected).
  - key_s=1 with cnt==DEBOUNCE_CYCLES-1 -> PRESSED, hold<=1.
  - key_s=1 otherwise -> cnt++.
- PRESSED:
  - key_s=0 -> DB_RELEASE, cnt<=1, short_pending<=1. Release has priority over reaching the threshold on the same edge.
  - key_s=1 with hold==LONG_CYCLES-1 -> LONG_HELD, key_long<=1 for that cycle only.
  - key_s=1 otherwise -> hold++.
- LONG_HELD: key_s=0 -> DB_RELEASE, cnt<=1, short_pending<=0. No further key_long while held, however long.
- DB_RELEASE:
  - key_s=1 -> return to PRESSED if short_pending, else LONG_HELD. hold is frozen (not cleared) and no pulse is emitted.
  - key_s=0 with cnt==DEBOUNCE_CYCLES-1 -> IDLE; key_short<=short_pending for one cycle.
  - key_s=0 otherwise -> cnt++.
- key_pressed = 1 in PRESSED, LONG_HELD and DB_RELEASE; registered with the state.
- Latency, press stable from E0:
  - key_pressed rises after edge E(DEBOUNCE_CYCLES+1).
  - key_long is high after edge E(DEBOUNCE_CYCLES+LONG_CYCLES).
- Latency, release stable from R0: key_short is high (or key_pressed falls) after edge R(DEBOUNCE_CYCLES+1).
- Pulse exclusivity: at most one of key_short/key_long per press, never both; each is high for exactly one cycle.
- Counter widths: $clog2(max value + 1). Counters never wrap, because the terminal compare always causes an exit from the state.
- Reset mid-operation: next state is IDLE with outputs 0 and no pulse. A key still held after reset is re-debounced as a new press.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, KEY_ACTIVE_LOW=1):
1. rst=1 for 3 cycles with key_raw=0 (pressed) -> during reset all outputs 0, state=0. After rst drops, key_pressed rises 5 edges after the first sampling edge.
2. Clean press, key_raw=0 for 10 cycles, then 1 -> key_pressed=1 after E5. key_long never asserts. key_short=1 for exactly one cycle after R5, with key_pressed=0 and state=0 in the same cycle.
3. Hold key_raw=0 for 40 cycles -> key_long=1 for one cycle after E24 and state=3. On release, no key_short; key_pressed falls after R5.
4. Press bounce, key_raw pattern 0,0,1 repeated 3 times, then stable 0 -> state never reaches 2 during the bounce. key_pressed rises 5 edges after the stable level starts; exactly one key_short after a clean release.
5. In PRESSED (hold=8), release glitch of 2 cycles then pressed again -> state 4 then back to 2, no pulse. hold resumes from 8, so key_long asserts 12 PRESSED-cycles later if still held.
6. In LONG_HELD, assert rst for 1 cycle while key is held -> next cycle state=0 and all outputs 0. The FSM then re-debounces; releasing within 20 cycles gives exactly one key_short.

Source files
------------

// File: rtl/key_press_classifier.sv
// key_press_classifier
//
// Front end for the push button that drives the clock state machine.
// The raw button level is brought into the clk domain by a 2-FF
// synchroniser. Presses and releases are both debounced, and each press is
// then classified as short or long:
//   - key_short pulses for one cycle when a press is released before the
//     long threshold is reached.
//   - key_long pulses for one cycle as soon as the debounced hold time
//     reaches the threshold. A press that has fired key_long never
//     produces key_short.
//
// Ports
//   clk          system clock, all logic on posedge
//   rst          synchronous, active-high reset
//   key_raw      asynchronous, bouncing button level
//   key_short    one-cycle pulse, short press completed
//   key_long     one-cycle pulse, long threshold reached
//   key_pressed  debounced press level (debug/LED)
//   state        current FSM state code (debug)
//
// States
//   state      | code | meaning
//   IDLE       | 0    | no press, waiting for key_s = 1
//   DB_PRESS   | 1    | counting stable pressed samples
//   PRESSED    | 2    | press accepted, counting hold time
//   LONG_HELD  | 3    | long pulse already issued, waiting for release
//   DB_RELEASE | 4    | counting stable released samples
//   (codes 5-7 are illegal and return to IDLE)

module key_press_classifier #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_raw,
    output logic       key_short,
    output logic       key_long,
    output logic       key_pressed,
    output logic [2:0] state
);

    // Counters only ever hold 0 .. LIMIT-1, because the terminal compare
    // always leaves the counting state.
    localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    localparam logic RELEASED_LVL = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_DB_PRESS   = 3'd1,
        S_PRESSED    = 3'd2,
        S_LONG_HELD  = 3'd3,
        S_DB_RELEASE = 3'd4
    } state_t;

    logic [1:0]        sync_q;
    logic              key_s;

    state_t            state_q, state_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [HOLD_W-1:0] hold_q, hold_n;
    logic              short_pending_q, short_pending_n;
    logic              short_n, long_n, pressed_n;

    // Reset loads the released level so that a reset never looks like a
    // press edge to the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {2{RELEASED_LVL}};
        end else begin
            sync_q <= {sync_q[0], key_raw};
        end
    end

    assign key_s = KEY_ACTIVE_LOW ? ~sync_q[1] : sync_q[1];

    always_comb begin
        state_n         = state_q;
        cnt_n           = cnt_q;
        hold_n          = hold_q;
        short_pending_n = short_pending_q;
        short_n         = 1'b0;
        long_n          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (key_s) begin
                    state_n = S_DB_PRESS;
                    cnt_n   = CNT_ONE;
                end
            end

            S_DB_PRESS: begin
                if (!key_s) begin
                    state_n = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_n = S_PRESSED;
                    hold_n  = HOLD_ONE;
                end else begin
                    cnt_n = cnt_q + CNT_ONE;
                end
            end

            // A release on the same edge as the threshold wins: the press
            // never became long.
            S_PRESSED: begin
                if (!key_s) begin
                    state_n         = S_DB_RELEASE;
                    cnt_n           = CNT_ONE;
                    short_pending_n = 1'b1;
                end else if (hold_q == HOLD_LAST) begin
                    state_n = S_LONG_HELD;
                    long_n  = 1'b1;
                end else begin
                    hold_n = hold_q + HOLD_ONE;
                end
            end

            S_LONG_HELD: begin
                if (!key_s) begin
                    state_n         = S_DB_RELEASE;
                    cnt_n           = CNT_ONE;
                    short_pending_n = 1'b0;
                end
            end

            // A release glitch returns to where it came from; hold is left
            // untouched so the press keeps its accumulated time.
            S_DB_RELEASE: begin
                if (key_s) begin
                    state_n = short_pending_q ? S_PRESSED : S_LONG_HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_n = S_IDLE;
                    short_n = short_pending_q;
                end else begin
                    cnt_n = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase

        pressed_n = (state_n == S_PRESSED) || (state_n == S_LONG_HELD) ||
                    (state_n == S_DB_RELEASE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            hold_q          <= '0;
            short_pending_q <= 1'b0;
            key_short       <= 1'b0;
            key_long        <= 1'b0;
            key_pressed     <= 1'b0;
        end else begin
            state_q         <= state_n;
            cnt_q           <= cnt_n;
            hold_q          <= hold_n;
            short_pending_q <= short_pending_n;
            key_short       <= short_n;
            key_long        <= long_n;
            key_pressed     <= pressed_n;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_key_press_classifier.sv
module tb_key_press_classifier;

    localparam int D = 4;
    localparam int L = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_raw = 1'b1;
    logic       key_short, key_long, key_pressed;
    logic [2:0] state;

    always #5 clk = ~clk;

    key_press_classifier #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES    (L),
        .KEY_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_raw    (key_raw),
        .key_short  (key_short),
        .key_long   (key_long),
        .key_pressed(key_pressed),
        .state      (state)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: tracks the synchronised sample stream and reasons in
    // terms of run lengths of identical samples. A press is accepted once D
    // pressed samples in a row are seen, a release once D released samples
    // in a row are seen. Hold time advances on pressed samples that follow
    // another pressed sample while accepted; a sample that ends a release
    // glitch does not count.
    logic m_s1 = 1'b1, m_s2 = 1'b1;
    bit   m_pressed = 0, m_long_done = 0, m_prev = 0;
    int   m_run = 0, m_hold = 0;
    bit   e_short = 0, e_long = 0;
    logic [2:0] e_state = 3'd0;
    int   obs_short = 0, obs_long = 0;

    task automatic model_step(input logic raw, input logic r);
        bit ks;
        e_short = 0;
        e_long  = 0;
        if (r) begin
            m_s1 = 1'b1; m_s2 = 1'b1;
            m_pressed = 0; m_long_done = 0; m_prev = 0;
            m_run = 0; m_hold = 0;
        end else begin
            ks   = ~m_s2;
            m_s2 = m_s1;
            m_s1 = raw;
            if (ks == m_prev) m_run = (m_run < 1000) ? m_run + 1 : m_run;
            else              m_run = 1;
            m_prev = ks;
            if (!m_pressed) begin
                if (ks && m_run == D) begin
                    m_pressed = 1; m_hold = 1; m_long_done = 0;
                end
            end else if (!ks) begin
                if (m_run == D) begin
                    m_pressed = 0;
                    e_short   = !m_long_done;
                end
            end else if (m_run >= 2 && !m_long_done) begin
                if (m_hold == L - 1) begin
                    m_long_done = 1;
                    e_long      = 1;
                end else begin
                    m_hold++;
                end
            end
        end
        if (!m_pressed)      e_state = m_prev ? 3'd1 : 3'd0;
        else if (!m_prev)    e_state = 3'd4;
        else                 e_state = m_long_done ? 3'd3 : 3'd2;
    endtask

    task automatic tick(input logic raw, input logic r);
        key_raw = raw;
        rst     = r;
        @(posedge clk);
        model_step(raw, r);
        #1;
        if (key_short === 1'b1) obs_short++;
        if (key_long === 1'b1)  obs_long++;
        check("key_short",   {31'd0, key_short},   {31'd0, e_short});
        check("key_long",    {31'd0, key_long},    {31'd0, e_long});
        check("key_pressed", {31'd0, key_pressed}, {31'd0, m_pressed});
        check("state",       {29'd0, state},       {29'd0, e_state});
    endtask

    // Pressed level for KEY_ACTIVE_LOW = 1 is raw 0.
    task automatic hold_lvl(input logic raw, input int n);
        for (int i = 0; i < n; i++) tick(raw, 1'b0);
    endtask

    task automatic expect_pulses(input string tag, input int shorts, input int longs);
        check({tag, "_short_count"}, obs_short, shorts);
        check({tag, "_long_count"},  obs_long,  longs);
        obs_short = 0;
        obs_long  = 0;
    endtask

    initial begin
        // 1: reset while pressed, then the press is debounced afresh
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
        hold_lvl(1'b0, 15);
        hold_lvl(1'b1, 10);
        expect_pulses("t1", 1, 0);

        // 2: clean short press
        hold_lvl(1'b0, 10);
        hold_lvl(1'b1, 10);
        expect_pulses("t2", 1, 0);

        // 3: long hold, no short on release
        hold_lvl(1'b0, 40);
        hold_lvl(1'b1, 10);
        expect_pulses("t3", 0, 1);

        // 4: bouncing press then a clean release
        for (int i = 0; i < 3; i++) begin
            hold_lvl(1'b0, 2);
            hold_lvl(1'b1, 1);
        end
        hold_lvl(1'b0, 10);
        hold_lvl(1'b1, 10);
        expect_pulses("t4", 1, 0);

        // 5: release glitch at hold 8, hold time resumes, then long
        hold_lvl(1'b0, 11);
        hold_lvl(1'b1, 2);
        hold_lvl(1'b0, 30);
        hold_lvl(1'b1, 10);
        expect_pulses("t5", 0, 1);

        // 6: reset in LONG_HELD while still held, then a short press
        hold_lvl(1'b0, 40);
        tick(1'b0, 1'b1);
        hold_lvl(1'b0, 10);
        hold_lvl(1'b1, 10);
        expect_pulses("t6", 1, 1);

        // Randomised segments: stable levels, bounce bursts, rare resets
        for (int s = 0; s < 800; s++) begin
            int kind;
            kind = int'($urandom_range(0, 29));
            if (kind == 0) begin
                for (int i = 0; i < int'($urandom_range(1, 2)); i++)
                    tick(1'(($urandom_range(0, 1))), 1'b1);
            end else if (kind < 10) begin
                for (int i = 0; i < int'($urandom_range(1, 8)); i++)
                    tick(1'($urandom_range(0, 1)), 1'b0);
            end else begin
                hold_lvl(1'($urandom_range(0, 1)), int'($urandom_range(1, 45)));
            end
        end
        hold_lvl(1'b1, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
